seg_scan_display: RTL
=====================

# seg_scan_display

Parametrised multiplexed seven-segment display driver: latches a packed hex word, time-multiplexes it across `DIGITS` common-anode digits with a built-in scan prescaler, anti-ghosting dead time, per-digit decimal points, per-digit blanking and optional leading-zero suppression. It sits between the switch/data path and the board display pins. It replaces a fixed 4-digit driver fed from an external divided clock, and runs directly on the system clock.

## Interface
Parameters:
- `DIGITS`, 8: number of digits scanned; legal 1..16.
- `SCAN_DIV`, 50000: `clk` cycles per digit slot; legal ≥ 2.
- `BLANK_CYCLES`, 2: dead-time cycles at the start of each slot with all selects inactive; legal 0..`SCAN_DIV`-1.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `din` in 4*`DIGITS`: packed nibbles; `din[4i+3:4i]` is digit i; digit 0 is least significant (rightmost).
- `we` in 1: load strobe; `din`, `dp`, `blank_mask` are captured when high.
- `dp` in `DIGITS`: decimal point enable per digit, captured with `we`.
- `blank_mask` in `DIGITS`: 1 forces digit i dark, captured with `we`.
- `lz_en` in 1: leading-zero suppression enable (live, not latched).
- `sel` out `DIGITS`: digit selects, active-low.
- `seg` out 8: segments, active-low; `seg[7]`=dp, `seg[6:0]`=g,f,e,d,c,b,a.

## Operation
- Shadow registers `data_q`, `dp_q`, `blank_q`: loaded on any edge with `rst_n`=1 and `we`=1. Otherwise held.
- Prescaler `cnt` counts 0..`SCAN_DIV`-1 and then wraps to 0. The scan index `idx` increments when `cnt`=`SCAN_DIV`-1, wrapping from `DIGITS`-1 to 0.
- Hex decode, shown as active-high g..a before inversion: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Digit i is dark when any of the following holds:
  - `blank_q[i]`=1; or
  - `lz_en`=1, i≠0, and nibbles i..`DIGITS`-1 of `data_q` are all zero.
- A dark digit drives `seg`=8'hFF, with its dp also off. Its select is still asserted.
- A lit digit drives `seg` = ~{`dp_q[i]`, decode(nibble i)}.
- Selects:
  - `cnt` < `BLANK_CYCLES`: `sel` is all ones and `seg`=8'hFF.
  - Otherwise: `sel` = ~(1<<`idx`), exactly one bit low.
- `DIGITS`=1: `idx` is constantly 0 and no wrap logic is needed.

## Timing
- Reset: `cnt`=0, `idx`=0, `data_q`=0, `dp_q`=0, `blank_q`=0. `sel` = all ones and `seg`=8'hFF on the edge where `rst_n`=0.
- Reset mid-slot aborts the slot. The first slot after release is digit 0, starting with the dead time.
- `sel` and `seg` are registered from (`cnt`, `idx`, shadow registers, `lz_en`). Latency from these to the pins is 1 cycle.
- A `we` capture at edge t reaches the pins at edge t+1 if the displayed digit changed.
- A `we` held high continuously reloads every cycle; no glitch beyond the normal 1-cycle latency.
- A `we` at the same edge as an `idx` advance: the new slot shows the new data one cycle later, consistent with the 1-cycle latency.
- Slot period is exactly `SCAN_DIV` cycles. Full frame is `DIGITS`×`SCAN_DIV` cycles. Selects are low for `SCAN_DIV`-`BLANK_CYCLES` cycles per slot.
- With `BLANK_CYCLES`=0, consecutive selects switch on the same edge with no overlap.

## Test plan
Bench parameters: `DIGITS`=4, `SCAN_DIV`=4, `BLANK_CYCLES`=1.
- Reset, then release with `din`=16'h0000 and `lz_en`=0:
  - `sel` is 4'hF and `seg` is 8'hFF during reset and for the first dead cycle.
  - Then `sel`=4'hE and `seg`=8'hC0 for 3 cycles.
  - Then `sel`=4'hF for 1 cycle, then `sel`=4'hD.
- Load `din`=16'h1A3F with `dp`=4'b0100:
  - Slot sequence is `sel` E→D→B→7.
  - `seg` sequence is 8E, B0, 08 (dp on), F9.
  - The sequence repeats every 16 cycles.
- Load `din`=16'h0050 with `lz_en`=1:
  - Digits 3 and 2 show `seg`=8'hFF with selects still asserted.
  - Digit 1 shows 92 and digit 0 shows C0.
  - `din`=16'h0000 shows only digit 0 as C0.
- Load `blank_mask`=4'b0010 with `din`=16'h8888: digit 1 slot shows `seg`=8'hFF; all others show 80.
- Pulse `we` with a new value at the cycle where `cnt`=3: the next slot's `seg` reflects the new value on its first non-dead cycle.
- Assert `rst_n`=0 for 1 cycle mid-slot at `idx`=2: the next edge gives `sel`=4'hF; after release the scan restarts at digit 0 and `data_q` reads back 0.

Source files
------------

// File: rtl/seg_scan_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_display_if
//  Description : Data/display bundle for the multiplexed seven-segment
//                driver.
//                Signals (master = data source, slave = display driver):
//                  din        packed hex nibbles, digit 0 rightmost
//                  we         load strobe for din / dp / blank_mask
//                  dp         decimal-point enable per digit
//                  blank_mask force-dark mask per digit
//                  lz_en      leading-zero suppression (live)
//                  sel        digit selects, active-low
//                  seg        segments {dp,g..a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_display_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] din;
  logic                we;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank_mask;
  logic                lz_en;
  logic [DIGITS-1:0]   sel;
  logic [7:0]          seg;

  modport master (
    output din, we, dp, blank_mask, lz_en,
    input  sel, seg
  );

  modport slave (
    input  din, we, dp, blank_mask, lz_en,
    output sel, seg
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_display
//  Description : Multiplexed common-anode seven-segment driver. Latches a
//                packed hex word and scans it across DIGITS digits with a
//                built-in prescaler, dead time at the start of each slot,
//                per-digit decimal points, blanking and optional leading-zero
//                suppression. Runs directly on the system clock.
//  Ports       : clk    system clock, rising edge
//                rst_n  synchronous active-low reset
//                bus    seg_scan_display_if.slave (din/we/dp/blank_mask/
//                       lz_en in, sel/seg out; outputs registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seg_scan_display_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;

  logic                slot_end;
  logic                in_dead;
  logic [DIGITS-1:0]   zero_from;
  logic [3:0]          nib;
  logic [6:0]          hex7;
  logic                dark;

  // --------------------------------------------------------------------------
  // Shadow registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (bus.we) begin
      data_q  <= bus.din;
      dp_q    <= bus.dp;
      blank_q <= bus.blank_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Slot prescaler and scan index
  // --------------------------------------------------------------------------
  assign slot_end = (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (DIGITS > 1) begin : g_idx_scan
      localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          idx_q <= '0;
        end else if (slot_end) begin
          idx_q <= (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
    end else begin : g_idx_single
      assign idx_q = '0;
    end
  endgenerate

  // Dead time occupies the first BLANK_CYCLES counts of every slot.
  generate
    if (BLANK_CYCLES > 0) begin : g_dead
      localparam logic [CNT_W-1:0] C_BLANK = CNT_W'(BLANK_CYCLES);
      assign in_dead = (cnt_q < C_BLANK);
    end else begin : g_no_dead
      assign in_dead = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Digit content
  // --------------------------------------------------------------------------
  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero, scanning down
  // from the most significant digit.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (data_q[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
  end

  assign nib  = 4'(data_q >> {idx_q, 2'b00});
  assign dark = blank_q[idx_q] | (bus.lz_en & (idx_q != '0) & zero_from[idx_q]);

  always_comb begin
    hex7 = 7'h00;
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  end

  // Dark digits keep their select asserted; only the segments go off.
  always_comb begin
    sel_d = '1;
    seg_d = 8'hFF;
    if (!in_dead) begin
      sel_d = ~(DIGITS'(1) << idx_q);
      seg_d = dark ? 8'hFF : ~{dp_q[idx_q], hex7};
    end
  end

  // --------------------------------------------------------------------------
  // Registered pin drivers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= '1;
      seg_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;

endmodule
`default_nettype wire
